// File: rtl/traffic_request_arbiter_pkg.sv
// Shared definitions for the pedestrian/lane request arbiter: FSM states, lane indices
// and the round-robin pick helper.
package traffic_request_arbiter_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;
  localparam logic [1:0] LANE_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } arbState_t;

  // Walk downward so the last hit (closest to ptr, wrapping) is the one returned.
  function automatic logic [1:0] rrPick(input logic [NUM_LANES-1:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rrPick = ptr;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rrPick = idx;
    end
  endfunction

endpackage

// File: rtl/traffic_request_arbiter_debounce.sv
// One lane of button conditioning: 2-flop synchroniser, counter debouncer and a one-cycle
// pulse on each accepted rising edge of the debounced level.
module lane_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btnRaw,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_syncMeta;
  logic             r_syncOut;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;

  // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_syncMeta <= 1'b0;
      r_syncOut  <= 1'b0;
      r_level    <= 1'b0;
      r_cnt      <= '0;
      r_rise     <= 1'b0;
    end else begin
      r_syncMeta <= i_btnRaw;
      r_syncOut  <= r_syncMeta;
      r_rise     <= 1'b0;
      if (r_syncOut != r_level) begin
        if (r_cnt == DEB_LAST) begin
          r_level <= r_syncOut;
          r_cnt   <= '0;
          r_rise  <= r_syncOut;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/traffic_request_arbiter.sv
// Conditions four raw buttons into latched pending requests and offers them one at a time,
// round-robin, as a one-hot request to the traffic light controller.
module traffic_request_arbiter
  import traffic_request_arbiter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 2,
  parameter int CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] btn_raw,
  input  logic                 serve_ack,
  output logic [NUM_LANES-1:0] req_p,
  output logic [NUM_LANES-1:0] pending,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    (HOLDOFF_CYCLES == 0) ? '0 : CNT_W'(HOLDOFF_CYCLES - 1);

  logic [NUM_LANES-1:0] w_rise;

  arbState_t            r_state,   w_stateNext;
  logic [NUM_LANES-1:0] r_reqP,    w_reqPNext;
  logic [NUM_LANES-1:0] r_pending, w_pendingNext;
  logic [1:0]           r_rrPtr,   w_rrPtrNext;
  logic [1:0]           r_grant,   w_grantNext;
  logic [CNT_W-1:0]     r_gapCnt,  w_gapCntNext;
  logic [1:0]           w_pick;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .i_btnRaw(btn_raw[g]),
      .o_rise  (w_rise[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_reqP    <= '0;
      r_pending <= '0;
      r_rrPtr   <= LANE_A;
      r_grant   <= LANE_A;
      r_gapCnt  <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_reqP    <= w_reqPNext;
      r_pending <= w_pendingNext;
      r_rrPtr   <= w_rrPtrNext;
      r_grant   <= w_grantNext;
      r_gapCnt  <= w_gapCntNext;
    end
  end

  // A rise arriving with the ack is OR-ed in after the clear, so a fresh press survives.
  always_comb begin
    w_stateNext   = r_state;
    w_reqPNext    = r_reqP;
    w_pendingNext = r_pending | w_rise;
    w_rrPtrNext   = r_rrPtr;
    w_grantNext   = r_grant;
    w_gapCntNext  = r_gapCnt;
    w_pick        = rrPick(r_pending, r_rrPtr);
    unique case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_grantNext = w_pick;
          w_reqPNext  = NUM_LANES'(1) << w_pick;
          w_stateNext = OFFER;
        end
      end
      OFFER: begin
        if (serve_ack) begin
          w_pendingNext = (r_pending & ~r_reqP) | w_rise;
          w_reqPNext    = '0;
          w_rrPtrNext   = (r_grant == LANE_D) ? LANE_A : r_grant + 2'd1;
          w_gapCntNext  = '0;
          w_stateNext   = (HOLDOFF_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (r_gapCnt == HOLD_LAST) begin
          w_gapCntNext = '0;
          w_stateNext  = IDLE;
        end else begin
          w_gapCntNext = r_gapCnt + 1'b1;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_reqPNext  = '0;
      end
    endcase
  end

  assign req_p   = r_reqP;
  assign pending = r_pending;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_traffic_request_arbiter.sv
// Self-checking bench: a cycle-level behavioural model of the arbiter is compared against the
// DUT every cycle, plus directed scenarios with hand-computed expectations.
module tb_traffic_request_arbiter;

  localparam int D = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic       serve_ack = 1'b0;
  logic [3:0] req_p;
  logic [3:0] pending;
  logic       busy;

  int checks = 0;
  int errors = 0;

  traffic_request_arbiter #(
    .DEBOUNCE_CYCLES(D),
    .HOLDOFF_CYCLES (H),
    .CNT_W          (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .serve_ack(serve_ack),
    .req_p    (req_p),
    .pending  (pending),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw seen two edges late, level flips after D disagreeing samples, pending set the
  // edge after a rise, one offer at a time, next offer no earlier than H idle edges after an ack.
  bit [3:0] mPend, mRise, mLevel, h1, h2;
  int       mStreak[4];
  int       mGrant = -1;
  int       mPtr, cyc, mFreeAt;
  bit       modelValid = 1'b0;

  always @(posedge clk) begin
    bit [3:0] oldPend, oldRise;
    if (rst) begin
      mPend = 0; mRise = 0; mLevel = 0; h1 = 0; h2 = 0;
      mStreak = '{default: 0};
      mGrant = -1; mPtr = 0; cyc = 0; mFreeAt = 0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      cyc++;
      oldPend = mPend;
      oldRise = mRise;
      if (mGrant >= 0) begin
        if (serve_ack) begin
          mPend[mGrant] = 1'b0;
          mPtr = (mGrant + 1) % 4;
          mFreeAt = cyc + H;
          mGrant = -1;
        end
      end else if (cyc - 1 >= mFreeAt && oldPend != 0) begin
        for (int k = 3; k >= 0; k--)
          if (oldPend[(mPtr + k) % 4]) mGrant = (mPtr + k) % 4;
      end
      mPend |= oldRise;
      mRise = 0;
      for (int i = 0; i < 4; i++) begin
        if (h2[i] != mLevel[i]) begin
          mStreak[i]++;
          if (mStreak[i] == D) begin
            mLevel[i] = h2[i];
            mStreak[i] = 0;
            mRise[i] = h2[i];
          end
        end else begin
          mStreak[i] = 0;
        end
      end
      h2 = h1;
      h1 = btn_raw;
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      logic [3:0] expReq;
      expReq = (mGrant >= 0) ? (4'b0001 << mGrant) : 4'b0000;
      checkOutput("req_p", req_p, expReq);
      checkOutput("pending", pending, mPend);
      checkOutput("busy", {3'b000, busy}, {3'b000, (mGrant >= 0) || (cyc < mFreeAt)});
      checkOutput("onehot0", {3'b000, $onehot0(req_p)}, 4'b0001);
      checkOutput("req_in_pending", req_p & ~pending, 4'b0000);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] btn, input logic ack);
    btn_raw   = btn;
    serve_ack = ack;
  endtask

  task automatic pulseAck();
    serve_ack = 1'b1;
    tick();
    serve_ack = 1'b0;
  endtask

  task automatic waitReq(input int maxCycles, output int waited);
    waited = 0;
    while (req_p == 4'b0000 && waited < maxCycles) begin
      tick();
      waited++;
    end
    if (req_p == 4'b0000) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitReq timeout: got req_p %b expected nonzero within %0d cycles", req_p, maxCycles);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    logic [3:0] expG;

    // Test 1: single held press, exact latency, ack and holdoff.
    applyStimulus(4'b0000, 1'b0);
    repeat (3) tick();
    checkOutput("reset req_p", req_p, 4'b0000);
    checkOutput("reset pending", pending, 4'b0000);
    checkOutput("reset busy", {3'b000, busy}, 4'b0000);
    rst = 1'b0;
    applyStimulus(4'b0010, 1'b0);
    repeat (6) tick();
    checkOutput("t1 pending edge6", pending, 4'b0000);
    tick();
    checkOutput("t1 pending edge7", pending, 4'b0010);
    checkOutput("t1 req edge7", req_p, 4'b0000);
    tick();
    checkOutput("t1 req edge8", req_p, 4'b0010);
    checkOutput("t1 busy edge8", {3'b000, busy}, 4'b0001);
    repeat (4) tick();
    pulseAck();
    checkOutput("t1 req after ack", req_p, 4'b0000);
    checkOutput("t1 pending after ack", pending, 4'b0000);
    checkOutput("t1 busy gap1", {3'b000, busy}, 4'b0001);
    tick();
    checkOutput("t1 busy gap2", {3'b000, busy}, 4'b0001);
    tick();
    checkOutput("t1 busy idle", {3'b000, busy}, 4'b0000);
    applyStimulus(4'b0000, 1'b0);
    repeat (10) tick();

    // Test 2: 3-cycle glitch is rejected.
    applyStimulus(4'b0001, 1'b0);
    repeat (3) tick();
    applyStimulus(4'b0000, 1'b0);
    repeat (12) tick();
    checkOutput("t2 pending", pending, 4'b0000);
    checkOutput("t2 req", req_p, 4'b0000);

    // Test 3: all four together, round-robin order with gaps.
    doReset();
    applyStimulus(4'b1111, 1'b0);
    waitReq(20, n);
    for (int g = 0; g < 4; g++) begin
      expG = 4'b0001 << g;
      checkOutput("t3 grant order", req_p, expG);
      pulseAck();
      if (g < 3) begin
        waitReq(20, n);
        checkOutput("t3 idle gap >=2", {3'b000, n >= 2}, 4'b0001);
      end
    end
    applyStimulus(4'b0000, 1'b0);
    repeat (10) tick();

    // Test 4: re-press of the offered lane rises on the same edge as the ack.
    applyStimulus(4'b0100, 1'b0);
    waitReq(20, n);
    checkOutput("t4 first offer", req_p, 4'b0100);
    applyStimulus(4'b0000, 1'b0);
    repeat (8) tick();
    applyStimulus(4'b0100, 1'b0);
    repeat (6) tick();
    pulseAck();
    checkOutput("t4 pending set wins", pending, 4'b0100);
    checkOutput("t4 req dropped", req_p, 4'b0000);
    waitReq(20, n);
    checkOutput("t4 re-offer", req_p, 4'b0100);
    pulseAck();
    applyStimulus(4'b0000, 1'b0);
    repeat (10) tick();

    // Test 5: reset mid-offer with pointer away from lane 0.
    applyStimulus(4'b1000, 1'b0);
    waitReq(20, n);
    checkOutput("t5 offer lane3", req_p, 4'b1000);
    applyStimulus(4'b1001, 1'b0);
    n = 0;
    while (pending != 4'b1001 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t5 pending before rst", pending, 4'b1001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5 req after rst", req_p, 4'b0000);
    checkOutput("t5 pending after rst", pending, 4'b0000);
    checkOutput("t5 busy after rst", {3'b000, busy}, 4'b0000);
    waitReq(20, n);
    checkOutput("t5 offer from lane0", req_p, 4'b0001);

    // Test 6: ack in GAP and in IDLE is ignored.
    pulseAck();
    pulseAck();
    checkOutput("t6 pending after gap ack", pending, 4'b1000);
    checkOutput("t6 req in gap", req_p, 4'b0000);
    waitReq(20, n);
    checkOutput("t6 next offer lane3", req_p, 4'b1000);
    pulseAck();
    applyStimulus(4'b0000, 1'b0);
    repeat (10) tick();
    pulseAck();
    checkOutput("t6 idle ack pending", pending, 4'b0000);
    checkOutput("t6 idle ack busy", {3'b000, busy}, 4'b0000);
    applyStimulus(4'b0011, 1'b0);
    waitReq(20, n);
    checkOutput("t6 ptr kept at lane0", req_p, 4'b0001);
    pulseAck();
    applyStimulus(4'b0000, 1'b0);
    repeat (10) tick();

    // Random phase: run-length button activity, random acks and rare resets.
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] b;
      b = btn_raw;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) b[i] = ~b[i];
      btn_raw = b;
      if (req_p != 4'b0000) serve_ack = ($urandom_range(0, 3) == 0);
      else serve_ack = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    applyStimulus(4'b0000, 1'b0);
    rst = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
